dt1_mem_lsu: RTL and testbench

- Memory-stage load/store unit for the dt1 RV32I pipeline; it produces the load data that the writeback stage selects as ReadDataW.
- Converts M-stage load/store controls into a req/gnt/rvalid data-bus transaction.
- Generates byte enables, replicates store data onto the correct lanes, and extracts and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/dt1_mem_lsu_if.sv | 21 ++
 rtl/dt1_mem_lsu.sv | 177 +++++++++++++++++
 tb/tb_dt1_mem_lsu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dt1_mem_lsu_if.sv
// Data-bus interface between the load/store unit and data memory.
interface dt1_mem_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/dt1_mem_lsu.sv
// dt1 memory-stage load/store unit: M-stage controls to req/gnt/rvalid bus, with load extension.
module dt1_mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [2:0]          funct3M,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         WriteDataM,
    dt1_mem_lsu_if.master       dmem,
    output logic [31:0]         ReadDataM,
    output logic                StallM,
    output logic [1:0]          ExcM
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               to_flag;

    // Request attributes captured at issue so the bus stays stable through REQ/WAIT
    logic [XLEN-1:0]    lat_addr;
    logic [XLEN-1:0]    lat_wdata;
    logic [3:0]         lat_be;
    logic               lat_we;
    logic               lat_load;
    logic [1:0]         lat_size;
    logic               lat_uns;
    logic [1:0]         lat_lane;

    logic               access, illegal, misaligned, issue, timeout_hit;
    logic [3:0]         be_c;
    logic [XLEN-1:0]    wdata_c;
    logic [XLEN-1:0]    load_ext_c;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    // Legality, alignment and lane generation for the instruction currently in M
    always_comb begin
        access  = MemReadM | MemWriteM;
        illegal = access && ((MemReadM && MemWriteM) ||
                  (MemReadM  && !(funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                  (MemWriteM && !(funct3M inside {3'b000, 3'b001, 3'b010})));
        misaligned = access && !illegal &&
                     ((funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                      (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00));
        issue = access && !illegal && !misaligned;
        case (funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ALUResultM[1:0];
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = WriteDataM;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned word using latched attributes
    always_comb begin
        byte_sel = dmem.dmem_rdata[8*lat_lane +: 8];
        half_sel = lat_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (lat_size)
            2'b00:   load_ext_c = lat_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext_c = lat_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext_c = dmem.dmem_rdata;
        endcase
        timeout_hit = (9'(cnt) + 9'd1) >= 9'(TIMEOUT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (issue) state_nx = dmem.dmem_gnt ? S_WAIT : S_REQ;
            S_REQ:  if (dmem.dmem_gnt) state_nx = S_WAIT;
            S_WAIT: if (dmem.dmem_rvalid || timeout_hit) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus, stall and exception outputs; IDLE drives the bus straight from the M-stage inputs
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = lat_we;
        dmem.dmem_be    = lat_be;
        dmem.dmem_addr  = lat_addr;
        dmem.dmem_wdata = lat_wdata;
        StallM          = 1'b0;
        ExcM            = 2'b00;
        case (state)
            S_IDLE: begin
                dmem.dmem_we    = MemWriteM;
                dmem.dmem_be    = be_c;
                dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
                dmem.dmem_wdata = wdata_c;
                if (illegal)         ExcM = 2'b11;
                else if (misaligned) ExcM = 2'b01;
                if (issue) begin
                    dmem.dmem_req = 1'b1;
                    StallM        = 1'b1;
                end
            end
            S_REQ: begin
                dmem.dmem_req = 1'b1;
                StallM        = 1'b1;
            end
            S_WAIT: StallM = 1'b1;
            S_DONE: ExcM = to_flag ? 2'b10 : 2'b00;
            default: ;
        endcase
    end

    // Request capture, timeout counter and load result register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            to_flag   <= 1'b0;
            ReadDataM <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_we    <= 1'b0;
            lat_load  <= 1'b0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
            lat_lane  <= '0;
        end else begin
            case (state)
                S_IDLE: if (issue) begin
                    lat_addr  <= {ALUResultM[31:2], 2'b00};
                    lat_wdata <= wdata_c;
                    lat_be    <= be_c;
                    lat_we    <= MemWriteM;
                    lat_load  <= MemReadM;
                    lat_size  <= funct3M[1:0];
                    lat_uns   <= funct3M[2];
                    lat_lane  <= ALUResultM[1:0];
                    cnt       <= '0;
                    to_flag   <= 1'b0;
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem.dmem_rvalid) begin
                        if (lat_load) ReadDataM <= load_ext_c;
                    end else if (timeout_hit) begin
                        to_flag <= 1'b1;
                    end
                end
                S_DONE: begin
                    cnt     <= '0;
                    to_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt1_mem_lsu.sv
// Self-checking bench for dt1_mem_lsu: directed table, corner sequences, random vs. reference model.
module tb_dt1_mem_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic [1:0]  ExcM;

    dt1_mem_lsu_if bus();

    dt1_mem_lsu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .dmem       (bus.master),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .ExcM       (ExcM)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observations collected by run_txn
    int          o_reqs, o_stall;
    logic        o_done, o_stable, o_we;
    logic [1:0]  o_exc;
    logic [31:0] o_rdm, o_addr, o_wdata;
    logic [3:0]  o_be;

    // Present one instruction in M and act as memory: gnt after gd refused request cycles,
    // rvalid in the rl-th cycle after the grant (rl<=0: never). Returns at posedge+1 after completion.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                           input int gd, input int rl);
        logic granted;
        int   waits;
        granted = 1'b0; waits = 0;
        o_reqs = 0; o_stall = 0; o_done = 1'b0; o_stable = 1'b1;
        o_exc = '0; o_rdm = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        bus.dmem_rdata = rdata;
        for (int c = 0; c < 40 && !o_done; c++) begin
            bus.dmem_gnt    = !granted && (o_reqs == gd);
            bus.dmem_rvalid = granted && (rl > 0) && (waits + 1 == rl);
            @(negedge clk);
            if (bus.dmem_req) begin
                if (o_reqs == 0) begin
                    o_addr = bus.dmem_addr; o_be = bus.dmem_be;
                    o_wdata = bus.dmem_wdata; o_we = bus.dmem_we;
                end else if (bus.dmem_addr !== o_addr || bus.dmem_be !== o_be ||
                             bus.dmem_wdata !== o_wdata || bus.dmem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                o_reqs++;
                if (bus.dmem_gnt) granted = 1'b1;
            end else if (granted && StallM) begin
                waits++;
            end
            if (StallM) o_stall++;
            else begin
                o_done = 1'b1; o_exc = ExcM; o_rdm = ReadDataM;
            end
            @(posedge clk); #1;
        end
        if (!o_done) begin
            n_cmp++; n_mis++;
            $display("FAIL txn_bound: stall never released, got busy expected done");
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, rdata;
        int          gd, rl;
        logic [1:0]  exc;
        logic [31:0] rdm;
        int          reqs, stall;
        logic        chk_bus, we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl[13];

    // Reference model: specification rules in plain arithmetic
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_exc(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a);
        if (!(rd || wr)) return 2'b00;
        if (rd && wr) return 2'b11;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b11;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2'b11;
        if ((a % nbytes(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int n;
        logic [31:0] v, mask;
        n    = nbytes(f3);
        v    = w >> (8 * (a % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v    = v & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] ones;
        ones = 4'((1 << nbytes(f3)) - 1);
        return ones << (a % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction

    task automatic check_obs(input string tag, input vec_t v);
        chk({tag, "_exc"},   32'(o_exc), 32'(v.exc));
        chk({tag, "_rdata"}, o_rdm, v.rdm);
        chk({tag, "_stall"}, 32'(o_stall), 32'(v.stall));
        chk({tag, "_reqs"},  32'(o_reqs), 32'(v.reqs));
        if (v.chk_bus) begin
            chk({tag, "_addr"},   o_addr, {v.a[31:2], 2'b00});
            chk({tag, "_be"},     32'(o_be), 32'(v.be));
            chk({tag, "_wdata"},  o_wdata, v.wdata);
            chk({tag, "_we"},     32'(o_we), 32'(v.we));
            chk({tag, "_stable"}, 32'(o_stable), 32'd1);
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] m_rdm;
        int          r, wc;
        logic [2:0]  f3opt[8];

        //            rd    wr    f3      addr      wdata         rdata         gd rl  exc    rdm           reqs stall bus  we    be       wdata
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF7F01, 0, 1, 2'b00, 32'hFFFFFF80, 1, 2, 1'b1, 1'b0, 4'b1000, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF7F01, 0, 1, 2'b00, 32'h00000080, 1, 2, 1'b1, 1'b0, 4'b1000, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF7F01, 0, 1, 2'b00, 32'hFFFF80FF, 1, 2, 1'b1, 1'b0, 4'b1100, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h55555555, 0, 2, 2'b00, 32'hFFFF80FF, 1, 3, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h040, 32'h0,        32'hDEADBEEF, 3, 2, 2'b00, 32'hDEADBEEF, 4, 6, 1'b1, 1'b0, 4'b1111, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h003, 32'h0,        32'h11111111, 0, 1, 2'b01, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 3'b010, 32'h010, 32'h0,        32'h11111111, 0, 1, 2'b11, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'h11111111, 0, 1, 2'b11, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h22222222, 0, 0, 2'b10, 32'hDEADBEEF, 1, 5, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'b101, 32'h101, 32'h0,        32'h11111111, 0, 1, 2'b01, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h11111111, 0, 1, 2'b11, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 3'b000, 32'h001, 32'h000000A5, 32'h33333333, 1, 4, 2'b00, 32'hDEADBEEF, 2, 6, 1'b1, 1'b1, 4'b0010, 32'hA5A5A5A5};
        tbl[12] = '{1'b1, 1'b0, 3'b100, 32'h002, 32'h0,        32'h00C30000, 0, 1, 2'b00, 32'h000000C3, 1, 2, 1'b1, 1'b0, 4'b0100, 32'h0};

        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = '0; ALUResultM = '0; WriteDataM = '0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_rdata", ReadDataM, 32'h0);
        chk("reset_req",   32'(bus.dmem_req), 32'd0);
        chk("reset_stall", 32'(StallM), 32'd0);
        chk("reset_exc",   32'(ExcM), 32'd0);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            v = tbl[i];
            run_txn(v.rd, v.wr, v.f3, v.a, v.wd, v.rdata, v.gd, v.rl);
            check_obs($sformatf("vec%0d", i), v);
        end

        // Timeout followed by a stray rvalid while idle
        run_txn(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h44444444, 0, 0);
        chk("late_exc", 32'(o_exc), 32'd2);
        bus.dmem_rdata = 32'hFFFFFFFF; bus.dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("late_req",   32'(bus.dmem_req), 32'd0);
        chk("late_stall", 32'(StallM), 32'd0);
        @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rdata", ReadDataM, 32'h000000C3);
        @(posedge clk); #1;

        // Reset while in WAIT abandons the access; a later rvalid is ignored
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h600; bus.dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rstw_req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        MemReadM = 1'b0; bus.dmem_gnt = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rstw_wait_stall", 32'(StallM), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstw_req0",  32'(bus.dmem_req), 32'd0);
        chk("rstw_stall", 32'(StallM), 32'd0);
        chk("rstw_rdata", ReadDataM, 32'h0);
        @(posedge clk); #1 bus.dmem_rdata = 32'h12345678; bus.dmem_rvalid = 1'b1;
        @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw_late_rdata", ReadDataM, 32'h0);
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        f3opt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        m_rdm = 32'h0;
        for (int t = 0; t < 200; t++) begin
            r    = $urandom_range(0, 9);
            v.rd = (r <= 4) || (r == 9);
            v.wr = (r >= 5);
            v.f3 = f3opt[(($urandom_range(0, 9)) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)];
            v.a  = $urandom;
            if ($urandom_range(0, 1) == 0) v.a[1:0] = 2'b00;
            v.wd    = $urandom;
            v.rdata = $urandom;
            v.gd    = $urandom_range(0, 3);
            v.rl    = $urandom_range(0, 6);
            v.exc   = m_exc(v.rd, v.wr, v.f3, v.a);
            v.chk_bus = (v.exc == 2'b00);
            v.reqs  = 0; v.stall = 0;
            v.we = v.wr; v.be = m_be(v.f3, v.a); v.wdata = v.wr ? m_wdata(v.f3, v.wd) : 32'h0;
            if (v.exc == 2'b00) begin
                wc = (v.rl >= 1 && v.rl <= int'(TO)) ? v.rl : int'(TO);
                v.reqs  = v.gd + 1;
                v.stall = v.reqs + wc;
                if (!(v.rl >= 1 && v.rl <= int'(TO))) v.exc = 2'b10;
                else if (v.rd) m_rdm = m_load(v.f3, v.a, v.rdata);
            end
            v.rdm = m_rdm;
            run_txn(v.rd, v.wr, v.f3, v.a, v.wd, v.rdata, v.gd, v.rl);
            if (!v.wr) o_wdata = 32'h0;
            check_obs($sformatf("rnd%0d", t), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
